// File: rtl/pll_rst_seq_pkg.sv
// rtl/pll_rst_seq_pkg.sv - state encodings and counter sizing for the PLL/reset sequencer
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  // Width of the failed-attempt counter exposed on the status port.
  localparam int RETRY_W = 4;

  // A counter that runs 0..n-1 needs clog2(n) bits; keep at least one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lock_sync_2ff.sv
// rtl/lock_sync_2ff.sv - two-flop synchronizer for the asynchronous PLL lock
module lock_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; reset drops the synced lock to 0 immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL reset/lock sequencing and staggered domain reset release
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES  = 8,
  parameter int LOCK_TIMEOUT    = 1000,
  parameter int LOCK_STABLE_CNT = 50,
  parameter int NUM_DOM         = 4,
  parameter int DOM_STAGGER     = 16,
  parameter int MAX_RETRY       = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pll_locked_i,
  input  logic                 sw_rst_req_i,
  output logic                 pll_rst_o,
  output logic [NUM_DOM-1:0]   dom_rst_n_o,
  output logic                 seq_done_o,
  output logic                 lock_fail_o,
  output logic [RETRY_W-1:0]   retry_cnt_o
);

  localparam int RC_W = cnt_w(PLL_RST_CYCLES);
  localparam int TO_W = cnt_w(LOCK_TIMEOUT);
  localparam int SB_W = cnt_w(LOCK_STABLE_CNT);
  localparam int SG_W = cnt_w(DOM_STAGGER);

  localparam logic [RC_W-1:0]    RC_LAST   = RC_W'(PLL_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [SB_W-1:0]    SB_LAST   = SB_W'(LOCK_STABLE_CNT - 1);
  localparam logic [SG_W-1:0]    SG_LAST   = SG_W'(DOM_STAGGER - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  state_t          state;
  logic            lock_s;
  logic [RC_W-1:0] rst_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [SB_W-1:0] stb_cnt;
  logic [SG_W-1:0] stg_cnt;

  lock_sync_2ff u_lock_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (pll_locked_i),
    .q   (lock_s)
  );

  // Sequencer: every counter defaults to 0 so only the active state's counter advances.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_PLL_RST;
      pll_rst_o   <= 1'b1;
      dom_rst_n_o <= '0;
      seq_done_o  <= 1'b0;
      lock_fail_o <= 1'b0;
      retry_cnt_o <= '0;
      rst_cnt     <= '0;
      to_cnt      <= '0;
      stb_cnt     <= '0;
      stg_cnt     <= '0;
    end else begin
      rst_cnt <= '0;
      to_cnt  <= '0;
      stb_cnt <= '0;
      stg_cnt <= '0;
      if (sw_rst_req_i) begin
        // Software request outranks lock loss and timeout seen in the same cycle.
        state       <= ST_PLL_RST;
        pll_rst_o   <= 1'b1;
        dom_rst_n_o <= '0;
        seq_done_o  <= 1'b0;
        lock_fail_o <= 1'b0;
        retry_cnt_o <= '0;
      end else begin
        case (state)
          ST_PLL_RST: begin
            if (rst_cnt == RC_LAST) begin
              state     <= ST_WAIT_LOCK;
              pll_rst_o <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt + RC_W'(1);
            end
          end
          ST_WAIT_LOCK: begin
            if (lock_s) begin
              state <= ST_STABLE;
            end else if (to_cnt == TO_LAST) begin
              retry_cnt_o <= retry_cnt_o + 4'd1;
              pll_rst_o   <= 1'b1;
              if ((retry_cnt_o + 4'd1) == RETRY_LIM) begin
                state       <= ST_FAIL;
                lock_fail_o <= 1'b1;
              end else begin
                state <= ST_PLL_RST;
              end
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          ST_STABLE: begin
            if (!lock_s) begin
              state <= ST_WAIT_LOCK;
            end else if (stb_cnt == SB_LAST) begin
              state       <= ST_RELEASE;
              dom_rst_n_o <= NUM_DOM'(1);
            end else begin
              stb_cnt <= stb_cnt + SB_W'(1);
            end
          end
          ST_RELEASE, ST_RUN: begin
            if (!lock_s) begin
              // Lock loss pulls every domain back into reset at once.
              state       <= ST_PLL_RST;
              pll_rst_o   <= 1'b1;
              dom_rst_n_o <= '0;
              seq_done_o  <= 1'b0;
            end else if (state == ST_RELEASE) begin
              if (stg_cnt == SG_LAST) begin
                if (&dom_rst_n_o) begin
                  state       <= ST_RUN;
                  seq_done_o  <= 1'b1;
                  retry_cnt_o <= '0;
                end else begin
                  // Released bits are contiguous from bit 0, so shifting in a 1 frees the next one.
                  dom_rst_n_o <= (dom_rst_n_o << 1) | NUM_DOM'(1);
                end
              end else begin
                stg_cnt <= stg_cnt + SG_W'(1);
              end
            end
          end
          ST_FAIL: begin
            pll_rst_o   <= 1'b1;
            dom_rst_n_o <= '0;
            lock_fail_o <= 1'b1;
          end
          default: begin
            state       <= ST_PLL_RST;
            pll_rst_o   <= 1'b1;
            dom_rst_n_o <= '0;
            seq_done_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb/tb_pll_rst_seq.sv - directed self-checking bench for pll_rst_seq
module tb_pll_rst_seq;

  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          locked = 1'b0;
  logic          sw = 1'b0;
  logic          pll_rst;
  logic [ND-1:0] dom;
  logic          done;
  logic          fail;
  logic [3:0]    retry;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .PLL_RST_CYCLES  (4),
    .LOCK_TIMEOUT    (20),
    .LOCK_STABLE_CNT (5),
    .NUM_DOM         (ND),
    .DOM_STAGGER     (2),
    .MAX_RETRY       (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pll_locked_i (locked),
    .sw_rst_req_i (sw),
    .pll_rst_o    (pll_rst),
    .dom_rst_n_o  (dom),
    .seq_done_o   (done),
    .lock_fail_o  (fail),
    .retry_cnt_o  (retry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Cycle n = state after the n-th rising edge following reset release; sampled 1 ns after the edge.
  task automatic run_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    locked = 1'b0;
    sw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pll", 32'(pll_rst), 1);
    chk("rst_dom", 32'(dom), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_retry", 32'(retry), 0);
    rst = 1'b0;
    cyc = 0;

    // 1: clean bring-up, lock raised after edge 10
    run_to(3);  chk("t1_pll_hi", 32'(pll_rst), 1);
    run_to(4);  chk("t1_pll_lo", 32'(pll_rst), 0);
    run_to(10); locked = 1'b1;
    run_to(17); chk("t1_dom_pre", 32'(dom), 0);
    run_to(18); chk("t1_dom_001", 32'(dom), 1);
    run_to(20); chk("t1_dom_011", 32'(dom), 3);
    run_to(22); chk("t1_dom_111", 32'(dom), 7);
                chk("t1_done_pre", 32'(done), 0);
    run_to(24); chk("t1_done", 32'(done), 1);
                chk("t1_retry", 32'(retry), 0);

    // 4: lock loss in RUN, then full re-sequence
    locked = 1'b0;
    run_to(26); chk("t4_dom_hold", 32'(dom), 7);
                chk("t4_done_hold", 32'(done), 1);
    run_to(27); chk("t4_dom_off", 32'(dom), 0);
                chk("t4_done_off", 32'(done), 0);
                chk("t4_pll_hi", 32'(pll_rst), 1);
    run_to(30); chk("t4_pll_hi_end", 32'(pll_rst), 1);
    run_to(31); chk("t4_pll_lo", 32'(pll_rst), 0);
    locked = 1'b1;
    run_to(38); chk("t4_dom_pre", 32'(dom), 0);
    run_to(39); chk("t4_dom_001", 32'(dom), 1);
    run_to(45); chk("t4_done", 32'(done), 1);
                chk("t4_dom_111", 32'(dom), 7);

    // 3: lock glitch during STABLE restarts qualification
    do_reset();
    run_to(10); locked = 1'b1;
    run_to(13); locked = 1'b0;
    run_to(14); locked = 1'b1;
    run_to(18); chk("t3_dom_early", 32'(dom), 0);
    run_to(21); chk("t3_dom_pre", 32'(dom), 0);
    run_to(22); chk("t3_dom_001", 32'(dom), 1);
                chk("t3_retry", 32'(retry), 0);
    run_to(24); chk("t3_dom_011", 32'(dom), 3);

    // 6: async reset mid-RELEASE
    #2;
    rst = 1'b1;
    #1;
    chk("t6_dom", 32'(dom), 0);
    chk("t6_pll", 32'(pll_rst), 1);
    chk("t6_done", 32'(done), 0);
    chk("t6_fail", 32'(fail), 0);
    chk("t6_retry", 32'(retry), 0);

    // 2: no lock ever
    do_reset();
    run_to(23); chk("t2_pll_lo1", 32'(pll_rst), 0);
                chk("t2_retry0", 32'(retry), 0);
    run_to(24); chk("t2_pll_hi2", 32'(pll_rst), 1);
                chk("t2_retry1", 32'(retry), 1);
                chk("t2_fail0", 32'(fail), 0);
    run_to(27); chk("t2_pll_hi2_end", 32'(pll_rst), 1);
    run_to(28); chk("t2_pll_lo2", 32'(pll_rst), 0);
    run_to(47); chk("t2_fail_pre", 32'(fail), 0);
    run_to(48); chk("t2_fail", 32'(fail), 1);
                chk("t2_retry2", 32'(retry), 2);
                chk("t2_pll_fail", 32'(pll_rst), 1);
                chk("t2_dom_fail", 32'(dom), 0);
    run_to(50); locked = 1'b1;
    run_to(54); chk("t2_fail_hold", 32'(fail), 1);
                chk("t2_pll_hold", 32'(pll_rst), 1);

    // 5: software request exits FAIL with lock present
    sw = 1'b1;
    run_to(55); sw = 1'b0;
    chk("t5_fail_clr", 32'(fail), 0);
    chk("t5_retry_clr", 32'(retry), 0);
    chk("t5_pll_hi", 32'(pll_rst), 1);
    run_to(59); chk("t5_pll_lo", 32'(pll_rst), 0);
    run_to(64); chk("t5_dom_pre", 32'(dom), 0);
    run_to(65); chk("t5_dom_001", 32'(dom), 1);
    run_to(71); chk("t5_done", 32'(done), 1);
                chk("t5_dom_111", 32'(dom), 7);
                chk("t5_retry_run", 32'(retry), 0);

    // 5b: software request coincides with lock loss in RUN
    locked = 1'b0;
    run_to(73); sw = 1'b1;
    run_to(74); sw = 1'b0;
    chk("t5b_dom", 32'(dom), 0);
    chk("t5b_done", 32'(done), 0);
    chk("t5b_pll", 32'(pll_rst), 1);
    chk("t5b_fail", 32'(fail), 0);
    run_to(77); chk("t5b_pll_hi_end", 32'(pll_rst), 1);
    run_to(78); chk("t5b_pll_lo", 32'(pll_rst), 0);

    // 5c: software request on the timeout edge suppresses the retry count
    run_to(97); chk("t5c_retry_pre", 32'(retry), 0);
    sw = 1'b1;
    run_to(98); sw = 1'b0;
    chk("t5c_retry", 32'(retry), 0);
    chk("t5c_pll", 32'(pll_rst), 1);
    run_to(101); chk("t5c_pll_hi_end", 32'(pll_rst), 1);
    run_to(102); chk("t5c_pll_lo", 32'(pll_rst), 0);
    run_to(122); chk("t5c_retry_timeout", 32'(retry), 1);
                 chk("t5c_fail0", 32'(fail), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
